channel_to_passive_fifo: RTL
============================

Name: channel_to_passive_fifo

Overview:
Buffered bridge from an active valid/data-acknowledge Channel (producer pushes, consumer acks) to a PassiveChannel (consumer requests with r, producer answers with a registered one-cycle v pulse). This is the producer end of the PassiveChannel protocol. It sits between Channel-based datapaths (merge/split trees) and blocks that pull data with r/v. An internal circular FIFO decouples the two handshakes.

Parameters:
N, 1, data width in bits (in.d, out.d).
Depth, 4, FIFO entries; power of two, >= 2.

Ports:
clk  input  1  clock; all state changes on posedge.
reset  input  1  asynchronous, active-high reset.
in  Channel #(N)  interface, consumer side: in.v input 1, in.d input N, in.a output 1.
out  PassiveChannel #(N)  interface, producer side: out.r input 1, out.d output N, out.v output 1.

Behaviour:
- Reset (async, posedge reset): wr_ptr=0, rd_ptr=0, count=0, out.v=0, out.d=0. in.a=0 while reset=1.
- Storage: Depth x N register array. Pointers are log2(Depth) bits and wrap naturally from Depth-1 to 0. count is log2(Depth)+1 bits, range 0..Depth.
- Input handshake:
  - in.a = ~reset & (count != Depth), combinational from registered state only; no path from in.v or out.r.
  - Push occurs at a posedge with in.v & in.a: mem[wr_ptr] <= in.d, wr_ptr++.
- Output handshake (registered, evaluated every posedge):
  - If out.r==1 and count!=0: out.v <= 1, out.d <= mem[rd_ptr], rd_ptr++ (pop).
  - Otherwise: out.v <= 0, and out.d holds its previous value.
  - A word is transferred in every cycle out.v==1. The consumer has promised acceptance by asserting r, so there is no stall path.
- count update: count <= count + push - pop. Simultaneous push and pop leaves count unchanged.
- Latency: a word pushed at edge k is presented (out.v=1) after edge k+1 at the earliest, given out.r=1 at edge k+1. There is no empty-to-output bypass.
- Throughput: with out.r held at 1 and in.v held at 1, one word per cycle in steady state. out.v stays continuously high once the FIFO is non-empty.
- Full: in.a=0 even if a pop occurs in the same cycle; the freed slot is visible to the producer on the next cycle. This is deliberate so that in.a does not depend on out.r.
- Empty with out.r=1: out.v=0, and nothing is popped.
- out.r falls: takes effect at the next posedge, so no out.v pulse follows an edge where out.r was sampled 0.
- Order: strict FIFO, and no word is dropped or duplicated.
- Mid-operation reset: all buffered words are discarded; out.v drops immediately (async), in.a drops immediately. After reset deasserts, the block behaves as fresh.

Optional Feature:
Macro CH2PC_LEVEL_EN.
- Defined: adds port "level  output  log2(Depth)+1  current count", registered, reset 0, updated on the same edge as count.
- Undefined: the port is absent and there is no extra logic.
- Handshake behaviour is identical either way.

Test Plan:
1. Reset, then push 0x1,0x2,0x3 (N=4) with out.r=0 -> in.a stays 1, out.v never asserts; raise out.r -> out.v high for 3 consecutive cycles with out.d=1,2,3, then 0.
2. Depth=4, out.r=0, in.v=1 continuously with data 5,6,7,8,9 -> exactly 4 words accepted, in.a=0 from the cycle after the 4th push; level=4 if CH2PC_LEVEL_EN.
3. Full FIFO, out.r=1 for one cycle -> one pop (out.d=5); in.a returns to 1 the following cycle, and 9 is accepted then, not earlier.
4. Single push at edge k into empty FIFO with out.r=1 throughout -> out.v=1 only after edge k+1, for exactly one cycle.
5. Streaming 100 random words, random in.v and random out.r gaps -> output sequence equals input sequence, with no out.v while out.r was sampled 0; exercises pointer wrap.
6. Assert reset while 3 words are buffered and out.v=1 -> out.v=0 and in.a=0 immediately; after release, out.v stays 0 until new pushes arrive and old data never appears.

Source files
------------

// File: rtl/channel_to_passive_fifo.sv
// channel_to_passive_fifo
//
// Buffered bridge from an active Channel (producer drives v/d, this block
// answers with a) to a PassiveChannel (consumer raises r, this block answers
// with a registered one-cycle v pulse carrying d). A circular FIFO of Depth
// entries decouples the two sides.
//
// Handshake semantics:
//   Input : a word moves on every posedge where in_v_i & in_a_o. in_a_o is
//           derived only from registered state (never from in_v_i or
//           out_r_i); it is low while the FIFO is full, even if a pop happens
//           in that same cycle.
//   Output: on every posedge where out_r_i is high and the FIFO is non-empty,
//           the head word is popped into out_d_o and out_v_o is high for the
//           following cycle. Asserting r is a promise to accept, so there is
//           no stall path. out_d_o holds its value while out_v_o is low.
//
// Optional build macro CH2PC_LEVEL_EN adds level_o, the registered occupancy.
module channel_to_passive_fifo #(
  parameter int N     = 1,
  parameter int Depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_v_i,
  input  logic [N-1:0]             in_d_i,
  output logic                     in_a_o,
  input  logic                     out_r_i,
  output logic [N-1:0]             out_d_o,
  output logic                     out_v_o
`ifdef CH2PC_LEVEL_EN
  ,
  output logic [$clog2(Depth):0]   level_o
`endif
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;

  logic [N-1:0]  mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_v_q, out_v_d;
  logic [N-1:0]  out_d_q, out_d_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full   = (count_q == CW'(Depth));
  assign empty  = (count_q == '0);
  assign in_a_o = ~reset & ~full;
  assign push   = in_v_i & in_a_o;
  assign pop    = out_r_i & ~empty;

  assign out_v_o = out_v_q;
  assign out_d_o = out_d_q;

`ifdef CH2PC_LEVEL_EN
  // count_q is already a register updated on the same edge, so level is a tap.
  assign level_o = count_q;
`endif

  // Next-state for pointers, occupancy and the registered output stage.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    out_v_d  = 1'b0;
    out_d_d  = out_d_q;
    count_d  = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      out_v_d  = 1'b1;
      out_d_d  = mem_q[rd_ptr_q];
    end
  end

  // Control and output registers; reset discards all buffered words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_v_q  <= 1'b0;
      out_d_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_v_q  <= out_v_d;
      out_d_q  <= out_d_d;
    end
  end

  // Storage array; contents need no reset since count_q gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_d_i;
    end
  end

endmodule
